// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared types and constants for the grayscale row scheduler
package gs_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, FILL, COMP, DONE} gs_state_t;

    localparam int GS_IMG_W = 1280;
    localparam int GS_IMG_H = 960;
    localparam int GS_PIX_W = 12;
endpackage

// File: rtl/gs_row_sched_if.sv
// rtl/gs_row_sched_if.sv - SDRAM write-side 1 request bundle
interface gs_row_sched_if #(
    parameter int ADDR_W = 23
) ();
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_load;
    logic              wr_full;

    modport master (output wr_req, output wr_addr, output wr_load, input wr_full);
    modport slave  (input wr_req, input wr_addr, input wr_load, output wr_full);
endinterface

// File: rtl/gs_addr_gen.sv
// rtl/gs_addr_gen.sv - wrapping write address counter
module gs_addr_gen #(
    parameter int ADDR_W    = 23,
    parameter int BASE_ADDR = 0,
    parameter int MAX_ADDR  = 307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (clear_i)
            addr_d = BASE;
        else if (advance_i)
            addr_d = (addr_q == LAST) ? BASE : addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            addr_q <= BASE;
        else
            addr_q <= addr_d;
    end

    assign addr_o = addr_q;
endmodule

// File: rtl/gs_row_sched.sv
// rtl/gs_row_sched.sv - row/column scheduler for the Bayer-to-grayscale write path
module gs_row_sched import gs_pkg::*; #(
    parameter int IMG_W     = GS_IMG_W,
    parameter int IMG_H     = GS_IMG_H,
    parameter int ADDR_W    = 23,
    parameter int BASE_ADDR = 0,
    parameter int MAX_ADDR  = 307200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pix_dval,
    gs_row_sched_if.master        wr_if,
    output logic                  lb_clken,
    output logic                  avg_en,
    output logic [10:0]           col_cnt,
    output logic [9:0]            row_cnt,
    output logic                  frame_done,
    output logic                  ovf
);
    localparam logic [10:0] COL_LAST = 11'(IMG_W - 1);
    localparam logic [9:0]  ROW_LAST = 10'(IMG_H - 1);

    gs_state_t   state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        avg_q, avg_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;
    logic        active, enter_load, pix_acc, wr_try, wr_req;

    assign active     = (state_q == FILL) || (state_q == COMP);
    // frame_start restarts from any state except LOAD, which is already a restart
    assign enter_load = frame_start && (state_q != LOAD);
    assign pix_acc    = active && pix_dval && !frame_start;
    // a restart (or reset) kills whatever write is still in the pipeline
    assign wr_try     = pend_q && !frame_start && !rst;
    assign wr_req     = wr_try && !wr_if.wr_full;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ovf_d   = ovf_q;
        avg_d   = pix_acc && (state_q == COMP) && col_q[0];
        pend_d  = avg_q && !frame_start;
        if (enter_load) begin
            state_d = LOAD;
            col_d   = '0;
            row_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (wr_try && wr_if.wr_full)
                ovf_d = 1'b1;
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: state_d = FILL;
                FILL, COMP: begin
                    if (pix_acc) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                state_d = DONE;
                            end else begin
                                row_d   = row_q + 10'd1;
                                state_d = (state_q == FILL) ? COMP : FILL;
                            end
                        end else begin
                            col_d = col_q + 11'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            avg_q   <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            avg_q   <= avg_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    gs_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .MAX_ADDR  (MAX_ADDR)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (enter_load),
        .advance_i (wr_req),
        .addr_o    (wr_if.wr_addr)
    );

    assign wr_if.wr_req  = wr_req;
    assign wr_if.wr_load = (state_q == LOAD);
    assign lb_clken      = active && pix_dval;
    assign avg_en        = avg_q;
    assign frame_done    = (state_q == DONE);
    assign ovf           = ovf_q;
    assign col_cnt       = col_q;
    assign row_cnt       = row_q;
endmodule

// File: tb/tb_gs_row_sched.sv
// tb/tb_gs_row_sched.sv - scoreboard bench for gs_row_sched on a small frame
module tb_gs_row_sched;
    localparam int W      = 8;
    localparam int H      = 4;
    localparam int ADDR_W = 8;
    localparam int BASE   = 2;
    localparam int MAXA   = 8;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_ACT  = 2;
    localparam int S_DONE = 3;

    typedef struct {
        int addr;
        int cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_dval = 1'b0;
    logic        lb_clken, avg_en, frame_done, ovf;
    logic [10:0] col_cnt;
    logic [9:0]  row_cnt;

    gs_row_sched_if #(.ADDR_W(ADDR_W)) wr_if ();

    gs_row_sched #(
        .IMG_W     (W),
        .IMG_H     (H),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .MAX_ADDR  (MAXA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_dval    (pix_dval),
        .wr_if       (wr_if),
        .lb_clken    (lb_clken),
        .avg_en      (avg_en),
        .col_cnt     (col_cnt),
        .row_cnt     (row_cnt),
        .frame_done  (frame_done),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_wr = 0, n_done = 0, n_load = 0;
    int  exp_wr = 0, exp_done = 0, exp_load = 0;
    int  m_st = S_IDLE, m_col = 0, m_row = 0, m_addr = BASE, m_wcnt = 0;
    int  drop_idx = -1;
    bit  exp_ovf = 1'b0;
    bit  prev_wp = 1'b0;
    bit  fp0 = 1'b0, fp1 = 1'b0;
    wr_t q[$];

    initial wr_if.wr_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (wr_if.wr_req === 1'b1) begin
            n_wr++;
            if (q.size() == 0) begin
                chk("wr_req_spurious", 32'(wr_if.wr_req), 32'(0));
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("wr_req_missing", 32'(wr_if.wr_req), 32'(1));
            e = q.pop_front();
        end
        if (frame_done === 1'b1) n_done++;
        if (wr_if.wr_load === 1'b1) n_load++;
    end

    task automatic clear_model();
        exp_wr -= q.size();
        q.delete();
        fp0    = 1'b0;
        fp1    = 1'b0;
        m_col  = 0;
        m_row  = 0;
        m_addr = BASE;
        m_wcnt = 0;
    endtask

    task automatic step(input bit dv, input bit fs, input bit rs);
        bit wp;
        @(posedge clk);
        #1;
        pix_dval      = dv;
        frame_start   = fs;
        rst           = rs;
        wr_if.wr_full = fp1;
        fp1 = fp0;
        fp0 = 1'b0;
        #1;
        chk("lb_clken", 32'(lb_clken), 32'(dv && m_st == S_ACT));
        chk("avg_en", 32'(avg_en), 32'(prev_wp));
        chk("wr_load", 32'(wr_if.wr_load), 32'(m_st == S_LOAD));
        chk("frame_done", 32'(frame_done), 32'(m_st == S_DONE));
        chk("col_cnt", 32'(col_cnt), 32'(m_col));
        chk("row_cnt", 32'(row_cnt), 32'(m_row));
        if (m_st == S_LOAD) chk("addr_load", 32'(wr_if.wr_addr), 32'(BASE));
        wp = 1'b0;
        if (rs) begin
            m_st = S_IDLE;
            clear_model();
            exp_ovf = 1'b0;
        end else if (fs && m_st != S_LOAD) begin
            m_st = S_LOAD;
            clear_model();
            exp_ovf = 1'b0;
            exp_load++;
        end else begin
            case (m_st)
                S_LOAD: m_st = S_ACT;
                S_DONE: m_st = S_IDLE;
                S_ACT: if (dv) begin
                    wp = (m_row % 2 == 1) && (m_col % 2 == 1);
                    if (m_col == W - 1) begin
                        m_col = 0;
                        if (m_row == H - 1) begin
                            m_row = 0;
                            m_st  = S_DONE;
                            exp_done++;
                        end else begin
                            m_row++;
                        end
                    end else begin
                        m_col++;
                    end
                end
                default: ;
            endcase
        end
        if (wp) begin
            if (m_wcnt == drop_idx) begin
                fp0     = 1'b1;
                exp_ovf = 1'b1;
            end else begin
                q.push_back('{addr: m_addr, cyc: cyc + 2});
                exp_wr++;
                m_addr = (m_addr == MAXA - 1) ? BASE : m_addr + 1;
            end
            m_wcnt++;
        end
        prev_wp = wp;
    endtask

    task automatic finish_frame(input int duty);
        int k = 0;
        while (m_st != S_IDLE && k < 1000) begin
            step($urandom_range(99, 0) < duty, 1'b0, 1'b0);
            k++;
        end
    endtask

    task automatic end_checks(input string tag);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk({tag, "_pending"}, 32'(q.size()), 32'(0));
        chk({tag, "_writes"}, 32'(n_wr), 32'(exp_wr));
        chk({tag, "_done_cnt"}, 32'(n_done), 32'(exp_done));
        chk({tag, "_load_cnt"}, 32'(n_load), 32'(exp_load));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic run_frame(input string tag, input int duty, input int drop);
        drop_idx = drop;
        step(1'b0, 1'b1, 1'b0);
        finish_frame(duty);
        end_checks(tag);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_ovf", 32'(ovf), 32'(0));
        chk("reset_wr_req", 32'(wr_if.wr_req), 32'(0));
        chk("reset_wr_addr", 32'(wr_if.wr_addr), 32'(BASE));
        step(1'b0, 1'b0, 1'b0);

        run_frame("cont", 100, -1);
        run_frame("drop", 100, 2);
        run_frame("gaps", 50, -1);

        // abort just after an odd-column COMP pixel: its write must vanish
        drop_idx = -1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (W + 2) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        finish_frame(100);
        end_checks("abort_mid");

        // restart coincident with the final pixel: no frame_done
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (W * H - 1) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        finish_frame(100);
        end_checks("abort_last");

        // synchronous reset in the middle of a COMP row
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (W + 4) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_mid_addr", 32'(wr_if.wr_addr), 32'(BASE));
        end_checks("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
